country_sensor_if: RTL and testbench

Conditions the country-road vehicle detector and produces the `X` demand input of the traffic light controller. It also closes the loop by watching the controller's `cntry` light code. It synchronizes and debounces the raw loop-detector contact and counts waiting vehicles, retiring one vehicle per departure interval while the country light is GREEN. `X` stays asserted exactly while the queue is non-empty. The block sits between the detector pad and the controller's `X` input, in the controller's clock domain.

---
 rtl/country_sensor_if.sv | 127 ++++++++++++
 tb/tb_country_sensor_if.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/country_sensor_if.sv
`default_nettype none
// ============================================================================
// Module      : country_sensor_if
// Description : Country-road vehicle detector conditioning. Synchronizes and
//               debounces the loop contact, queues arrivals, retires one
//               vehicle per departure interval while the country light is
//               GREEN, and raises X while vehicles are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module country_sensor_if #(
  parameter int DEBOUNCE      = 4,
  parameter int DEPART_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             loop_raw,
  input  logic [1:0]       cntry,
  output logic             X,
  output logic [CNT_W-1:0] queue_count,
  output logic             overflow
);

  localparam int DB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int DEP_W = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;

  localparam logic [DB_W-1:0]  c_db_last  = DB_W'(DEBOUNCE - 1);
  localparam logic [DEP_W-1:0] c_dep_last = DEP_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_q_max    = {CNT_W{1'b1}};
  localparam logic [1:0]       c_green    = 2'd2;

  logic             r_sync1;
  logic             r_loop_s;
  logic             r_loop_db;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_arrival;
  logic [DEP_W-1:0] r_dep_cnt;
  logic [CNT_W-1:0] r_queue_count;
  logic             r_overflow;

  logic             w_db_diff;
  logic             w_db_accept;
  logic             w_q_nonzero;
  logic             w_run;
  logic             w_depart;

  // A new level is accepted once it has differed for DEBOUNCE consecutive samples
  assign w_db_diff   = (r_loop_s != r_loop_db);
  assign w_db_accept = w_db_diff && (r_db_cnt == c_db_last);

  // The timer only advances while GREEN with someone waiting; its last count retires a vehicle
  assign w_q_nonzero = |r_queue_count;
  assign w_run       = (cntry == c_green) && w_q_nonzero;
  assign w_depart    = w_run && (r_dep_cnt == c_dep_last);

  // Two-flop synchronizer for the asynchronous loop contact
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_sync1  <= 1'b0;
      r_loop_s <= 1'b0;
    end else begin
      r_sync1  <= loop_raw;
      r_loop_s <= r_sync1;
    end
  end

  // Debounce: any return to the accepted level restarts the count
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_loop_db <= 1'b0;
      r_db_cnt  <= '0;
    end else if (!w_db_diff) begin
      r_db_cnt  <= '0;
    end else if (w_db_accept) begin
      r_loop_db <= r_loop_s;
      r_db_cnt  <= '0;
    end else begin
      r_db_cnt  <= r_db_cnt + 1'b1;
    end
  end

  // One-cycle arrival pulse on an accepted rising level only
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_arrival <= 1'b0;
    end else begin
      r_arrival <= w_db_accept && r_loop_s;
    end
  end

  // Departure timer; a partial interval is dropped whenever the run condition lapses
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_dep_cnt <= '0;
    end else if (!w_run || w_depart) begin
      r_dep_cnt <= '0;
    end else begin
      r_dep_cnt <= r_dep_cnt + 1'b1;
    end
  end

  // Queue bookkeeping; simultaneous arrival and departure cancel out
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_queue_count <= '0;
      r_overflow    <= 1'b0;
    end else begin
      case ({r_arrival, w_depart})
        2'b10: begin
          if (r_queue_count == c_q_max) begin
            r_overflow <= 1'b1;
          end else begin
            r_queue_count <= r_queue_count + 1'b1;
          end
        end
        2'b01:   r_queue_count <= r_queue_count - 1'b1;
        default: r_queue_count <= r_queue_count;
      endcase
    end
  end

  assign X           = w_q_nonzero;
  assign queue_count = r_queue_count;
  assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_country_sensor_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_country_sensor_if
// Description : Scoreboard bench for country_sensor_if. Two instances
//               (CNT_W=4 and CNT_W=2) share stimulus; a behavioural model
//               pushes expected outputs each edge, a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_country_sensor_if;

  localparam int DEBOUNCE      = 4;
  localparam int DEPART_CYCLES = 8;

  logic       clk      = 1'b0;
  logic       clear    = 1'b1;
  logic       loop_raw = 1'b0;
  logic [1:0] cntry    = 2'd0;

  logic       x_a, x_b;
  logic [3:0] qc_a;
  logic [1:0] qc_b;
  logic       ovf_a, ovf_b;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  country_sensor_if #(.DEBOUNCE(DEBOUNCE), .DEPART_CYCLES(DEPART_CYCLES), .CNT_W(4)) u_dut_a (
    .clk(clk), .clear(clear), .loop_raw(loop_raw), .cntry(cntry),
    .X(x_a), .queue_count(qc_a), .overflow(ovf_a)
  );

  country_sensor_if #(.DEBOUNCE(DEBOUNCE), .DEPART_CYCLES(DEPART_CYCLES), .CNT_W(2)) u_dut_b (
    .clk(clk), .clear(clear), .loop_raw(loop_raw), .cntry(cntry),
    .X(x_b), .queue_count(qc_b), .overflow(ovf_b)
  );

  typedef struct {
    int   q[2];
    logic ovf[2];
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Sampled detector history; a level is accepted once the last DEBOUNCE
  // samples all disagree with the currently accepted level.
  logic m_sync1 = 1'b0, m_loop_s = 1'b0, m_db = 1'b0, m_arr = 1'b0;
  logic m_hist[$];
  int   m_q[2]    = '{0, 0};
  int   m_green[2] = '{0, 0};
  logic m_ovf[2]  = '{1'b0, 1'b0};
  int   m_max[2]  = '{15, 3};

  always @(posedge clk) begin : model
    logic accept, dep;
    exp_t e;
    if (clear) begin
      m_sync1 = 0; m_loop_s = 0; m_db = 0; m_arr = 0;
      m_hist.delete();
      for (int j = 0; j < 2; j++) begin
        m_q[j] = 0; m_green[j] = 0; m_ovf[j] = 0;
      end
    end else begin
      m_hist.push_back(m_loop_s);
      if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
      accept = (m_hist.size() == DEBOUNCE);
      foreach (m_hist[i]) if (m_hist[i] == m_db) accept = 0;
      for (int j = 0; j < 2; j++) begin
        // m_green counts GREEN cycles already spent in the current departure interval
        dep = (cntry == 2'd2) && (m_q[j] > 0) && (m_green[j] + 1 == DEPART_CYCLES);
        if ((cntry == 2'd2) && (m_q[j] > 0)) m_green[j] = dep ? 0 : m_green[j] + 1;
        else m_green[j] = 0;
        if (m_arr && !dep) begin
          if (m_q[j] == m_max[j]) m_ovf[j] = 1;
          else m_q[j] = m_q[j] + 1;
        end else if (dep && !m_arr) begin
          m_q[j] = m_q[j] - 1;
        end
      end
      m_arr = accept && !m_db;
      if (accept) m_db = !m_db;
      m_loop_s = m_sync1;
      m_sync1  = loop_raw;
    end
    for (int j = 0; j < 2; j++) begin
      e.q[j]   = m_q[j];
      e.ovf[j] = m_ovf[j];
    end
    sb.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("qc_a",  int'(qc_a),  e.q[0]);
      check("x_a",   int'(x_a),   int'(e.q[0] != 0));
      check("ovf_a", int'(ovf_a), int'(e.ovf[0]));
      check("qc_b",  int'(qc_b),  e.q[1]);
      check("x_b",   int'(x_b),   int'(e.q[1] != 0));
      check("ovf_b", int'(ovf_b), int'(e.ovf[1]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic arrive();
    loop_raw = 1'b1; cyc(8);
    loop_raw = 1'b0; cyc(8);
  endtask

  initial begin
    cyc(3);
    clear = 1'b0;
    // single arrival
    arrive();
    // bounce: 3 high, 1 low, 2 high, then low
    loop_raw = 1'b1; cyc(3);
    loop_raw = 1'b0; cyc(1);
    loop_raw = 1'b1; cyc(2);
    loop_raw = 1'b0; cyc(8);
    // second arrival, then drain both under GREEN
    arrive();
    cntry = 2'd2; cyc(22);
    cntry = 2'd0; cyc(2);
    // interrupted GREEN then a full interval
    arrive();
    cntry = 2'd2; cyc(5);
    cntry = 2'd1; cyc(4);
    cntry = 2'd2; cyc(12);
    cntry = 2'd0; cyc(2);
    // queue 3, arrival pulse lands on the first departure edge
    arrive(); arrive(); arrive();
    cntry = 2'd2; cyc(1);
    loop_raw = 1'b1; cyc(8);
    loop_raw = 1'b0; cyc(8);
    cntry = 2'd3; cyc(2);
    // saturate the narrow instance
    cntry = 2'd0;
    repeat (5) arrive();
    // asynchronous clear in the middle of a cycle
    @(negedge clk);
    #2;
    clear = 1'b1;
    #1;
    check("async_qc_a",  int'(qc_a),  0);
    check("async_x_a",   int'(x_a),   0);
    check("async_ovf_a", int'(ovf_a), 0);
    check("async_qc_b",  int'(qc_b),  0);
    check("async_x_b",   int'(x_b),   0);
    check("async_ovf_b", int'(ovf_b), 0);
    cyc(1);
    clear = 1'b0;
    // randomized traffic
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 1) == 0) loop_raw = ~loop_raw;
      else cntry = ($urandom_range(0, 2) != 0) ? 2'd2 : 2'($urandom_range(0, 3));
      cyc($urandom_range(1, 10));
    end
    loop_raw = 1'b0;
    cntry = 2'd0;
    cyc(4);
    check("sb_drained", int'(sb.size() <= 1), 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
